seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Parametrised time-multiplexed driver for the board's seven-segment banks; next generation of the fixed 8-digit scanner. It takes pre-encoded segment patterns for DIGITS digits and scans them one-hot across the two segment buses. It adds an internal scan prescaler, frame-synchronous tear-free loading, 8-level brightness by PWM, and per-digit blinking. It sits between the message/digit encoders and the top-level segment pins.

## Interface
- DIGITS, 8, number of digits; even, 2..16; digits 0..DIGITS/2-1 on bank 0, the rest on bank 1
- SLOT_DIV, 12500, clock cycles per PWM phase; one digit slot = 8*SLOT_DIV cycles; must be ≥1
- BLINK_FRAMES, 64, complete scan frames per blink half-period; must be ≥1

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- digit_data  in  DIGITS*8  segment pattern, digit i at [8i+7:8i], active-high, 8'h00 = blank
- load  in  1  one-cycle strobe: capture digit_data for display
- blink_mask  in  DIGITS  1 = digit i blinks
- bright  in  3  duty level, on-phases per slot = bright+1 (0 → 1/8, 7 → full)
- seg_en  out  DIGITS  one-hot active-high digit enable, registered
- seg_out0  out  8  bank-0 segment pattern, registered
- seg_out1  out  8  bank-1 segment pattern, registered
- frame_tick  out  1  one-cycle pulse when scan index wraps to digit 0, registered

## Operation
- Counters: presc 0..SLOT_DIV-1; phase 0..7 advances when presc wraps; idx 0..DIGITS-1 advances when phase wraps from 7; idx wraps DIGITS-1 → 0 (frame boundary).
- Load path: pending register plus pending flag. On load, pending ← digit_data and flag set; a later load before the boundary overwrites pending (last wins).
- At frame boundary: shadow ← (load ? digit_data : pending) if load or flag; flag cleared. Load in the same cycle as the boundary goes straight to shadow.
- Display always reads shadow, never digit_data directly.
- Digit idx is lit iff phase ≤ bright and it is not blanked by blink. bright is sampled live each cycle.
- Lit: seg_en = 1<<idx.
  - idx < DIGITS/2: seg_out0 = shadow[idx], seg_out1 = 8'h00.
  - Otherwise: seg_out1 = shadow[idx], seg_out0 = 8'h00.
- Not lit: seg_en = 0, both seg_out = 8'h00 (no ghosting).
- Blink: frame counter 0..BLINK_FRAMES-1 advances on each boundary. blink_phase toggles on its wrap. While blink_phase = 1, digits with blink_mask[i] = 1 are not lit.

## Timing
- Reset (async assert, sync release by the board):
  - seg_en = 0, seg_out0 = seg_out1 = 0, frame_tick = 0
  - presc, phase, idx, frame counter, blink_phase = 0
  - shadow = pending = 0, flag = 0
- Outputs are registered: the values on the output pins are a function of the counter state in the previous cycle.
- First clock edge after release: seg_en = 1 (digit 0, phase 0 always lit unless blinked).
- Each digit is offered for 8*SLOT_DIV cycles. A frame is DIGITS*8*SLOT_DIV cycles.
- frame_tick is high exactly one cycle, coincident with the first cycle of digit 0 output of each new frame (not after reset).
- Load latency: new data appears from the first digit-0 slot after the next boundary, 1..frame length cycles after load.
- Blink half-period = BLINK_FRAMES frames; a blink change takes effect only at a frame boundary.
- Reset mid-frame or mid-load discards pending data and restarts at digit 0 with blank shadow.

## Configuration
- SEG_SCAN_BLINK_EN defined: frame counter, blink_phase and masking logic compiled in, as above.
- Not defined: blink_mask is ignored (port kept, unconnected internally), no blink counter, and masked digits are lit normally; all other behaviour is identical.

## Test plan
DIGITS=8, SLOT_DIV=2, BLINK_FRAMES=2 (slot 16 cycles, frame 128 cycles).
- Reset then bright=7, no load → seg_en walks 01,02,…,80 with 16 cycles each, seg_out0/1 = 00, frame_tick every 128 cycles.
- load with digit 0 = 8'h3F, digit 5 = 8'h6D mid-frame → old (blank) data until boundary; next frame gives seg_out0 = 3F during seg_en = 01 and seg_out1 = 6D during seg_en = 20.
- Two loads in one frame (0x11 then 0x22 on digit 0), plus load on the boundary cycle → last value displayed; boundary load visible in that same frame.
- bright=2 → each slot shows seg_en high for 6 cycles, low for 10 cycles; bright=0 → 2 on / 14 off.
- blink_mask = 8'h01 with SEG_SCAN_BLINK_EN → digit 0 lit in frames 0-1, dark in frames 2-3, repeating. Without the macro → always lit.
- rst_n pulsed low mid-slot of digit 4 → all outputs 0 immediately (asynchronous); after release, restart at digit 0 with blank data.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: signal bundle between the digit/message encoders
// (master) and the seven-segment scanner (slave).
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    logic [DIGITS*8-1:0] digit_data;
    logic                load;
    logic [DIGITS-1:0]   blink_mask;
    logic [2:0]          bright;
    logic [DIGITS-1:0]   seg_en;
    logic [7:0]          seg_out0;
    logic [7:0]          seg_out1;
    logic                frame_tick;

    modport master (
        output digit_data, load, blink_mask, bright,
        input  seg_en, seg_out0, seg_out1, frame_tick
    );

    modport slave (
        input  digit_data, load, blink_mask, bright,
        output seg_en, seg_out0, seg_out1, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scanner with a scan
// prescaler, frame-synchronous shadow loading, 8-level PWM brightness and
// optional per-digit blinking.
// Optional feature macro: SEG_SCAN_BLINK_EN (compiles in the blink frame
// counter and masking; when undefined blink_mask is ignored).
module seg_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SLOT_DIV     = 12500,
    parameter int BLINK_FRAMES = 64
) (
    input logic            clk,
    input logic            rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int PW = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0]     PRESC_MAX = PW'(SLOT_DIV - 1);
    localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [IW-1:0]     IDX_HALF  = IW'(DIGITS / 2);
    localparam logic [DIGITS-1:0] EN_ONE    = DIGITS'(1);

    // Scan counters
    logic [PW-1:0] r_presc;
    logic [2:0]    r_phase;
    logic [IW-1:0] r_idx;
    logic          r_bnd_p1;

    // Load path: pending buffer and the shadow copy that is displayed
    logic [DIGITS-1:0][7:0] r_pending;
    logic                   r_pend_flag;
    logic [DIGITS-1:0][7:0] r_shadow;

    // Registered outputs
    logic [DIGITS-1:0] r_seg_en;
    logic [7:0]        r_seg_out0;
    logic [7:0]        r_seg_out1;
    logic              r_frame_tick;

    logic                   w_presc_wrap;
    logic                   w_phase_wrap;
    logic                   w_boundary;
    logic                   w_blank;
    logic                   w_lit;
    logic [7:0]             w_pat;
    logic [DIGITS-1:0][7:0] w_data;

    assign w_data       = bus.digit_data;
    assign w_presc_wrap = (r_presc == PRESC_MAX);
    assign w_phase_wrap = w_presc_wrap && (r_phase == 3'd7);
    assign w_boundary   = w_phase_wrap && (r_idx == IDX_MAX);
    assign w_pat        = r_shadow[r_idx];
    assign w_lit        = (r_phase <= bus.bright) && !w_blank;

    // Prescaler -> PWM phase -> digit index chain; remember boundary for frame_tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_phase  <= '0;
            r_idx    <= '0;
            r_bnd_p1 <= 1'b0;
        end else begin
            r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
            if (w_presc_wrap) begin
                r_phase <= r_phase + 3'd1;
            end
            if (w_phase_wrap) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end
            r_bnd_p1 <= w_boundary;
        end
    end

    // Tear-free load: buffer mid-frame, commit to shadow only at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_pend_flag <= 1'b0;
            r_shadow    <= '0;
        end else if (w_boundary) begin
            if (bus.load) begin
                r_shadow <= w_data;
            end else if (r_pend_flag) begin
                r_shadow <= r_pending;
            end
            r_pend_flag <= 1'b0;
        end else if (bus.load) begin
            r_pending   <= w_data;
            r_pend_flag <= 1'b1;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] r_frame;
    logic          r_blink_phase;

    // Count whole frames and flip the blink phase every BLINK_FRAMES frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_boundary) begin
            if (r_frame == FRAME_MAX) begin
                r_frame       <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    assign w_blank = r_blink_phase && bus.blink_mask[r_idx];
`else
    logic w_unused_blink;
    assign w_unused_blink = ^{bus.blink_mask, BLINK_FRAMES[0]};
    assign w_blank        = 1'b0;
`endif

    // Drive one-hot enable and the owning bank; both banks dark when not lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_en     <= '0;
            r_seg_out0   <= '0;
            r_seg_out1   <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= r_bnd_p1;
            if (w_lit) begin
                r_seg_en <= EN_ONE << r_idx;
                if (r_idx < IDX_HALF) begin
                    r_seg_out0 <= w_pat;
                    r_seg_out1 <= 8'h00;
                end else begin
                    r_seg_out0 <= 8'h00;
                    r_seg_out1 <= w_pat;
                end
            end else begin
                r_seg_en   <= '0;
                r_seg_out0 <= 8'h00;
                r_seg_out1 <= 8'h00;
            end
        end
    end

    assign bus.seg_en     = r_seg_en;
    assign bus.seg_out0   = r_seg_out0;
    assign bus.seg_out1   = r_seg_out1;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with DIGITS=8,
// SLOT_DIV=2, BLINK_FRAMES=2 (16-cycle slot, 128-cycle frame).
module tb_seg_scan_ctrl;
    localparam int DIGITS = 8;
    localparam int FRAME  = 128;
    localparam int SLOT   = 16;
`ifdef SEG_SCAN_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    typedef struct {
        int         tag;
        int         c;
        logic [7:0] en;
        logic [7:0] o0;
        logic [7:0] o1;
        logic       ft;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   cnt;
    exp_t q[$];

    seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_ctrl #(
        .DIGITS      (DIGITS),
        .SLOT_DIV    (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if ({bus.seg_en, bus.seg_out0, bus.seg_out1, bus.frame_tick} !==
                {e.en, e.o0, e.o1, e.ft}) begin
                n_errors++;
                $display("FAIL scan_t%0d c=%0d: got en=%h o0=%h o1=%h ft=%b, want en=%h o0=%h o1=%h ft=%b",
                         e.tag, e.c, bus.seg_en, bus.seg_out0, bus.seg_out1, bus.frame_tick,
                         e.en, e.o0, e.o1, e.ft);
            end
        end
    end

    task automatic push_zero(input int tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag = tag; e.c = -1; e.en = 8'h00; e.o0 = 8'h00; e.o1 = 8'h00; e.ft = 1'b0;
            q.push_back(e);
        end
    endtask

    // Expected outputs for checks c_from..c_to (c counts cycles since reset release)
    task automatic push_range(input int tag, input int c_from, input int c_to,
                              input logic [2:0] br, input logic [63:0] data,
                              input logic [7:0] mask);
        for (int c = c_from; c <= c_to; c++) begin
            int   k;
            int   d;
            int   ph;
            logic lit;
            exp_t e;
            k   = c % FRAME;
            d   = k / SLOT;
            ph  = (k % SLOT) / 2;
            lit = (ph <= int'(br));
            if (BLINK_ON && mask[d] && (((c / FRAME) / 2) % 2 == 1)) lit = 1'b0;
            e.tag = tag;
            e.c   = c;
            e.en  = lit ? (8'd1 << d) : 8'd0;
            e.o0  = (lit && d < DIGITS / 2) ? data[d*8 +: 8] : 8'h00;
            e.o1  = (lit && d >= DIGITS / 2) ? data[d*8 +: 8] : 8'h00;
            e.ft  = (k == 0) && (c > 0);
            q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        cnt += n;
    endtask

    task automatic goto(input int e);
        if (e > cnt) step(e - cnt);
    endtask

    task automatic do_load(input int e, input logic [63:0] data);
        goto(e);
        bus.digit_data = data;
        bus.load       = 1'b1;
        step(1);
        bus.load       = 1'b0;
        bus.digit_data = '1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cnt      = 0;
        rst_n    = 1'b0;
        bus.digit_data = '0;
        bus.load       = 1'b0;
        bus.blink_mask = '0;
        bus.bright     = 3'd7;

        // Reset state, then free run blank at full brightness
        push_zero(0, 3);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt   = 0;
        push_zero(0, 1);
        push_range(1, 0, 255, 3'd7, 64'h0, 8'h00);

        // Mid-frame load appears only from the next frame
        do_load(FRAME + 50, 64'h0000_6D00_0000_003F);
        push_range(2, 256, 383, 3'd7, 64'h0000_6D00_0000_003F, 8'h00);

        // Two loads in one frame: last wins
        do_load(2*FRAME + 10, 64'h11);
        do_load(2*FRAME + 60, 64'h22);
        push_range(3, 384, 511, 3'd7, 64'h22, 8'h00);

        // Load on the boundary cycle goes straight into the next frame
        do_load(4*FRAME - 1, 64'h0000_0000_5500_0044);
        push_range(4, 512, 639, 3'd7, 64'h0000_0000_5500_0044, 8'h00);

        // Pending load overridden by a boundary load
        do_load(4*FRAME + 30, 64'h66);
        do_load(5*FRAME - 1, 64'h77);

        // Brightness 2 then 0
        goto(5*FRAME);
        bus.bright = 3'd2;
        push_range(5, 640, 767, 3'd2, 64'h77, 8'h00);
        goto(6*FRAME);
        bus.bright = 3'd0;
        push_range(6, 768, 895, 3'd0, 64'h77, 8'h00);

        // Blink digit 0 at full brightness
        goto(7*FRAME);
        bus.bright     = 3'd7;
        bus.blink_mask = 8'h01;
        push_range(7, 896, 1476, 3'd7, 64'h77, 8'h01);

        // Pending load then async reset mid-slot of digit 4
        do_load(11*FRAME + 12, 64'h99);
        goto(11*FRAME + 4*SLOT + 6);
        push_zero(8, 3);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        cnt   = 0;
        push_zero(8, 1);
        push_range(9, 0, 128, 3'd7, 64'h0, 8'h01);

        for (int i = 0; i < 400 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
